// File: rtl/maquina_param_if.sv
// Coin/dispense bus of the parametrised vending controller.
// master drives coins and cancel; slave is the controller itself.
interface maquina_param_if #(
  parameter int W = 8
);
  logic         e1;
  logic         e2;
  logic         cancel;
  logic [1:0]   state;
  logic         doce;
  logic         troco;
  logic         rej;
  logic [W-1:0] saldo;
  logic         busy;

  modport master (
    output e1, e2, cancel,
    input  state, doce, troco, rej, saldo, busy
  );

  modport slave (
    input  e1, e2, cancel,
    output state, doce, troco, rej, saldo, busy
  );
endinterface

// File: rtl/maquina_param.sv
// Two-coin vending controller with configurable coin values, price and serial change.
// Optional idle auto-refund is enabled by defining MAQ_TIMEOUT_EN.
module maquina_param #(
  parameter int W        = 8,
  parameter int PRICE    = 15,
  parameter int COIN_A   = 5,
  parameter int COIN_B   = 10,
  parameter int CHG_UNIT = 5,
  parameter int TIMEOUT  = 255
) (
  input logic            c,
  input logic            r,
  maquina_param_if.slave bus
);

  if (CHG_UNIT <= 0 || PRICE <= 0 || COIN_A <= 0 || COIN_B <= 0) begin : g_bad_zero
    $fatal(1, "maquina_param: PRICE, COIN_A, COIN_B and CHG_UNIT must be nonzero");
  end
  if ((PRICE % CHG_UNIT) != 0 || (COIN_A % CHG_UNIT) != 0 || (COIN_B % CHG_UNIT) != 0) begin : g_bad_mult
    $fatal(1, "maquina_param: PRICE, COIN_A and COIN_B must be multiples of CHG_UNIT");
  end
  if ((longint'(PRICE) - 1 + COIN_A + COIN_B) > ((longint'(1) << W) - 1)) begin : g_bad_width
    $fatal(1, "maquina_param: W too small, balance could overflow");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $fatal(1, "maquina_param: TIMEOUT must be at least 1");
  end

  localparam logic [W-1:0] PRICE_W = W'(PRICE);
  localparam logic [W-1:0] COIN_A_W = W'(COIN_A);
  localparam logic [W-1:0] COIN_B_W = W'(COIN_B);
  localparam logic [W-1:0] CHG_W = W'(CHG_UNIT);

  typedef enum logic [1:0] {
    ACC    = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } fsm_t;

  fsm_t         fsm, fsm_nx;
  logic [W-1:0] saldo, saldo_nx;
  logic         rej, rej_nx;
  logic [W-1:0] credit, sum, rest;
  logic         timeout_hit;

`ifdef MAQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt, idle_nx;

  // Counts only genuinely idle ACC cycles holding a balance; anything else restarts it.
  always_comb begin
    idle_nx     = '0;
    timeout_hit = 1'b0;
    if (fsm == ACC && saldo != '0 && !bus.e1 && !bus.e2 && !bus.cancel) begin
      if (idle_cnt == TW'(TIMEOUT - 1)) timeout_hit = 1'b1;
      else                              idle_nx     = idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge c or posedge r) begin
    if (r) idle_cnt <= '0;
    else   idle_cnt <= idle_nx;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    fsm_nx   = fsm;
    saldo_nx = saldo;
    rej_nx   = 1'b0;
    credit   = (bus.e1 ? COIN_A_W : '0) + (bus.e2 ? COIN_B_W : '0);
    sum      = saldo + credit;
    rest     = '0;
    case (fsm)
      ACC: begin
        if ((bus.cancel && saldo != '0) || timeout_hit) begin
          fsm_nx = CHANGE;
          rej_nx = bus.e1 | bus.e2;
        end else begin
          saldo_nx = sum;
          if (sum >= PRICE_W) fsm_nx = VEND;
        end
      end
      VEND: begin
        rej_nx   = bus.e1 | bus.e2;
        rest     = saldo - PRICE_W;
        saldo_nx = rest;
        fsm_nx   = (rest != '0) ? CHANGE : ACC;
      end
      CHANGE: begin
        rej_nx   = bus.e1 | bus.e2;
        rest     = saldo - CHG_W;
        saldo_nx = rest;
        if (rest == '0) fsm_nx = ACC;
      end
      default: fsm_nx = ACC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      fsm   <= ACC;
      saldo <= '0;
      rej   <= 1'b0;
    end else begin
      fsm   <= fsm_nx;
      saldo <= saldo_nx;
      rej   <= rej_nx;
    end
  end

  always_comb begin
    bus.state = 2'b00;
    case (fsm)
      VEND:    bus.state = (saldo == PRICE_W) ? 2'b10 : 2'b11;
      CHANGE:  bus.state = 2'b01;
      default: bus.state = 2'b00;
    endcase
  end

  assign bus.doce  = (fsm == VEND);
  assign bus.troco = (fsm == CHANGE);
  assign bus.busy  = (fsm != ACC);
  assign bus.rej   = rej;
  assign bus.saldo = saldo;

endmodule
